// File: rtl/reg_writeback_unit_pkg.sv
// wb_pkg: shared register-index width, parameter defaults and the writeback FIFO entry type.
package wb_pkg;
    localparam int REG_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH = 4;
    typedef struct packed {
        logic valid;
        logic killed;
        logic [REG_W-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_writeback_unit_if.sv
// reg_writeback_unit_if: ALU/multiply-divide result inputs, register-file write port and forwarding lookup.
interface reg_writeback_unit_if #(
    parameter int DATA_W = wb_pkg::DEF_DATA_W,
    parameter int DEPTH = wb_pkg::DEF_DEPTH
);
    import wb_pkg::*;
    logic alu_valid;
    logic [REG_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic md_valid;
    logic md_ready;
    logic [REG_W-1:0] md_reg;
    logic [DATA_W-1:0] md_data;
    logic RegWrite;
    logic [REG_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteRegData;
    logic [REG_W-1:0] fwd_reg;
    logic fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [$clog2(DEPTH):0] pending;
    modport master (
        output alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data, fwd_reg,
        input md_ready, RegWrite, WriteReg, WriteRegData, fwd_hit, fwd_data, pending
    );
    modport slave (
        input alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data, fwd_reg,
        output md_ready, RegWrite, WriteReg, WriteRegData, fwd_hit, fwd_data, pending
    );
endinterface

// File: rtl/reg_writeback_unit_fifo.sv
// wb_fifo: in-order multiply/divide result queue with kill-by-register and youngest-match lookup.
module wb_fifo #(
    parameter int DEPTH = wb_pkg::DEF_DEPTH,
    parameter int DATA_W = wb_pkg::DEF_DATA_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic [wb_pkg::REG_W-1:0] push_reg,
    input  logic [DATA_W-1:0] push_data,
    input  logic pop,
    input  logic kill,
    input  logic [wb_pkg::REG_W-1:0] kill_reg,
    input  logic [wb_pkg::REG_W-1:0] look_reg,
    output logic ready,
    output logic [$clog2(DEPTH):0] count,
    output logic head_killed,
    output logic [wb_pkg::REG_W-1:0] head_reg,
    output logic [DATA_W-1:0] head_data,
    output logic look_hit,
    output logic [DATA_W-1:0] look_data
);
    import wb_pkg::*;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [DEPTH-1:0] valid_q, killed_q;
    logic [REG_W-1:0] reg_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q, idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic ready_q;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);
    assign ready = ready_q;
    assign count = cnt_q;
    assign head_killed = killed_q[rd_q];
    assign head_reg = reg_q[rd_q];
    assign head_data = data_q[rd_q];
    // Walk oldest to youngest so the last live match is the youngest one.
    always_comb begin
        look_hit = 1'b0;
        look_data = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_q + PW'(k);
            if (valid_q[idx] && !killed_q[idx] && reg_q[idx] == look_reg) begin
                look_hit = 1'b1;
                look_data = data_q[idx];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            killed_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            ready_q <= cnt_d < CW'(DEPTH);
            if (push) wr_q <= wr_q + PW'(1);
            if (pop) rd_q <= rd_q + PW'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && rd_q == PW'(i)) valid_q[i] <= 1'b0;
                if (push && wr_q == PW'(i)) begin
                    valid_q[i] <= 1'b1;
                    killed_q[i] <= kill && kill_reg == push_reg;
                    reg_q[i] <= push_reg;
                    data_q[i] <= push_data;
                end else if (kill && valid_q[i] && reg_q[i] == kill_reg) begin
                    killed_q[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: merges single-cycle ALU results and queued multiply/divide results
// into one registered register-file write port, ALU first.
module reg_writeback_unit #(
    parameter int DEPTH = wb_pkg::DEF_DEPTH,
    parameter int DATA_W = wb_pkg::DEF_DATA_W
) (
    input logic clk,
    input logic rst_n,
    reg_writeback_unit_if.slave wb
);
    import wb_pkg::*;
    logic alu_sel, pop, push, ready;
    logic head_killed, look_hit;
    logic [REG_W-1:0] head_reg;
    logic [DATA_W-1:0] head_data, look_data;
    logic [$clog2(DEPTH):0] count;
    logic rw_q, rw_d;
    logic [REG_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic out_hit;
    // A register-0 ALU result is ignored entirely, so it never blocks the queue.
    always_comb begin
        alu_sel = wb.alu_valid && wb.alu_reg != '0;
        pop = !alu_sel && count != '0;
        push = wb.md_valid && ready && wb.md_reg != '0;
        rw_d = alu_sel || (pop && !head_killed);
        wreg_d = !rw_d ? wreg_q : alu_sel ? wb.alu_reg : head_reg;
        wdata_d = !rw_d ? wdata_q : alu_sel ? wb.alu_data : head_data;
        out_hit = rw_q && wreg_q == wb.fwd_reg;
    end
    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .push_reg(wb.md_reg),
        .push_data(wb.md_data),
        .pop(pop),
        .kill(alu_sel),
        .kill_reg(wb.alu_reg),
        .look_reg(wb.fwd_reg),
        .ready(ready),
        .count(count),
        .head_killed(head_killed),
        .head_reg(head_reg),
        .head_data(head_data),
        .look_hit(look_hit),
        .look_data(look_data)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q <= 1'b0;
            wreg_q <= '0;
            wdata_q <= '0;
        end else begin
            rw_q <= rw_d;
            wreg_q <= wreg_d;
            wdata_q <= wdata_d;
        end
    end
    assign wb.md_ready = ready;
    assign wb.pending = count;
    assign wb.RegWrite = rw_q;
    assign wb.WriteReg = wreg_q;
    assign wb.WriteRegData = wdata_q;
    assign wb.fwd_hit = wb.fwd_reg != '0 && (look_hit || out_hit);
    assign wb.fwd_data = !wb.fwd_hit ? '0 : look_hit ? look_data : wdata_q;
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed vector table, hand-written corner sequences and random
// traffic checked against a queue-based reference model.
module tb_reg_writeback_unit;
    import wb_pkg::*;
    localparam int DEPTH = 4;
    localparam int DATA_W = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    reg_writeback_unit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
    reg_writeback_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .wb(bus));

    int n_vec = 0;
    int n_err = 0;
    wb_entry_t mq[$];
    logic m_rw;
    logic [4:0] m_wr;
    logic [31:0] m_wd;
    logic m_rdy_en;
    logic e_rdy, e_hit;
    logic [31:0] e_fd;

    typedef struct {
        int av, ar, ad, mv, mr, md, fr;
        int rw, wr, wd, rdy, pend, fh, fd;
    } vec_t;
    vec_t tbl[14];
    int order[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rw = 1'b0;
        m_wr = '0;
        m_wd = '0;
        m_rdy_en = 1'b0;
    endtask

    task automatic apply(input int av, input int ar, input int ad, input int mv, input int mr, input int md, input int fr);
        bus.alu_valid = 1'(av);
        bus.alu_reg = 5'(ar);
        bus.alu_data = 32'(ad);
        bus.md_valid = 1'(mv);
        bus.md_reg = 5'(mr);
        bus.md_data = 32'(md);
        bus.fwd_reg = 5'(fr);
        #1;
    endtask

    // Compare against the model's view of this cycle, then advance the model across the edge.
    task automatic finish_cycle();
        logic sel, acc;
        wb_entry_t e;
        e_rdy = m_rdy_en && mq.size() < DEPTH;
        e_hit = 1'b0;
        e_fd = '0;
        if (bus.fwd_reg != 0) begin
            for (int i = mq.size() - 1; i >= 0 && !e_hit; i--)
                if (!mq[i].killed && mq[i].rd == bus.fwd_reg) begin
                    e_hit = 1'b1;
                    e_fd = mq[i].data;
                end
            if (!e_hit && m_rw && m_wr == bus.fwd_reg) begin
                e_hit = 1'b1;
                e_fd = m_wd;
            end
        end
        check("md_ready", 32'(bus.md_ready), 32'(e_rdy));
        check("pending", 32'(bus.pending), 32'(mq.size()));
        check("RegWrite", 32'(bus.RegWrite), 32'(m_rw));
        if (m_rw) begin
            check("WriteReg", 32'(bus.WriteReg), 32'(m_wr));
            check("WriteRegData", bus.WriteRegData, m_wd);
        end
        check("fwd_hit", 32'(bus.fwd_hit), 32'(e_hit));
        check("fwd_data", bus.fwd_data, e_fd);
        sel = bus.alu_valid && bus.alu_reg != 0;
        acc = bus.md_valid && e_rdy;
        if (sel) foreach (mq[i]) if (mq[i].rd == bus.alu_reg) mq[i].killed = 1'b1;
        if (sel) begin
            m_rw = 1'b1;
            m_wr = bus.alu_reg;
            m_wd = bus.alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_rw = !e.killed;
            if (!e.killed) begin
                m_wr = e.rd;
                m_wd = e.data;
            end
        end else begin
            m_rw = 1'b0;
        end
        if (acc && bus.md_reg != 0) begin
            e.valid = 1'b1;
            e.killed = sel && bus.md_reg == bus.alu_reg;
            e.rd = bus.md_reg;
            e.data = bus.md_data;
            mq.push_back(e);
        end
        m_rdy_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 5, 'h1234, 0, 0, 0, 5,   0, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 5,   1, 5, 'h1234, 1, 0, 1, 'h1234};
        tbl[3]  = '{0, 0, 0, 1, 7, 'hAAAA, 0,   0, 0, 0, 1, 0, 0, 0};
        tbl[4]  = '{1, 7, 'hBBBB, 0, 0, 0, 7,   0, 0, 0, 1, 1, 1, 'hAAAA};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 7,   1, 7, 'hBBBB, 1, 1, 1, 'hBBBB};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 7,   0, 0, 0, 1, 0, 0, 0};
        tbl[7]  = '{1, 9, 'h99, 1, 3, 1, 3,   0, 0, 0, 1, 0, 0, 0};
        tbl[8]  = '{1, 9, 'h99, 1, 3, 2, 3,   1, 9, 'h99, 1, 1, 1, 1};
        tbl[9]  = '{1, 9, 'h99, 0, 0, 0, 3,   1, 9, 'h99, 1, 2, 1, 2};
        tbl[10] = '{1, 0, 'hDEAD, 0, 0, 0, 3,   1, 9, 'h99, 1, 2, 1, 2};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 3,   1, 3, 1, 1, 1, 1, 2};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 3,   1, 3, 2, 1, 0, 1, 2};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0};

        apply(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
        check("rst_WriteReg", 32'(bus.WriteReg), 32'd0);
        check("rst_WriteRegData", bus.WriteRegData, 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_md_ready", 32'(bus.md_ready), 32'd0);
        model_reset();
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr, tbl[i].md, tbl[i].fr);
            check($sformatf("tbl%0d_rw", i), 32'(bus.RegWrite), 32'(tbl[i].rw));
            if (tbl[i].rw != 0) begin
                check($sformatf("tbl%0d_wr", i), 32'(bus.WriteReg), 32'(tbl[i].wr));
                check($sformatf("tbl%0d_wd", i), bus.WriteRegData, 32'(tbl[i].wd));
            end
            check($sformatf("tbl%0d_rdy", i), 32'(bus.md_ready), 32'(tbl[i].rdy));
            check($sformatf("tbl%0d_pend", i), 32'(bus.pending), 32'(tbl[i].pend));
            check($sformatf("tbl%0d_fh", i), 32'(bus.fwd_hit), 32'(tbl[i].fh));
            check($sformatf("tbl%0d_fd", i), bus.fwd_data, 32'(tbl[i].fd));
            finish_cycle();
        end

        // Fill the queue behind a busy ALU; the fifth result must wait for an idle ALU cycle.
        for (int k = 1; k <= 4; k++) begin
            apply(1, 9, 'h900 + k, 1, k, 'h100 + k, 0);
            finish_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            apply(1, 9, 'h990, 1, 5, 'h105, 0);
            check("full_md_ready", 32'(bus.md_ready), 32'd0);
            check("full_pending", 32'(bus.pending), 32'd4);
            finish_cycle();
        end
        apply(0, 0, 0, 1, 5, 'h105, 0);
        check("full_nobypass", 32'(bus.md_ready), 32'd0);
        finish_cycle();
        apply(0, 0, 0, 1, 5, 'h105, 0);
        check("refill_md_ready", 32'(bus.md_ready), 32'd1);
        if (bus.RegWrite && bus.WriteReg != 9) order.push_back(int'(bus.WriteReg));
        finish_cycle();
        for (int k = 0; k < 8; k++) begin
            apply(0, 0, 0, 0, 0, 0, 0);
            if (bus.RegWrite && bus.WriteReg != 9) order.push_back(int'(bus.WriteReg));
            finish_cycle();
        end
        check("order_len", 32'(order.size()), 32'd5);
        foreach (order[i]) check($sformatf("order%0d", i), 32'(order[i]), 32'(i + 1));

        // Reset with entries queued: nothing queued may ever reach the write port.
        for (int k = 1; k <= 3; k++) begin
            apply(1, 9, 'h77, 1, k, 'hC00 + k, 0);
            finish_cycle();
        end
        apply(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pending", 32'(bus.pending), 32'd0);
        check("midrst_RegWrite", 32'(bus.RegWrite), 32'd0);
        check("midrst_md_ready", 32'(bus.md_ready), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            apply(0, 0, 0, 0, 0, 0, 0);
            finish_cycle();
        end

        for (int k = 0; k < 1500; k++) begin
            apply(int'($urandom_range(0, 99) < 55), int'($urandom_range(0, 7)), int'($urandom),
                  int'($urandom_range(0, 99) < 60), int'($urandom_range(0, 7)), int'($urandom),
                  int'($urandom_range(0, 7)));
            finish_cycle();
        end
        for (int k = 0; k < 8; k++) begin
            apply(0, 0, 0, 0, 0, 0, int'($urandom_range(0, 7)));
            finish_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
